counter_sequencer: RTL and testbench

// Two-requester controller for the 8-bit up counter (Clock/Reset/Enable/Load/Data -> Count).

---
 rtl/counter_sequencer.sv | 103 ++++++++++
 tb/tb_counter_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Round-robin two-requester controller that drives an external up counter through
// load/enable and reports completion when the count reaches the winner's terminal value.
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqa,
  input  logic [WIDTH-1:0] starta,
  input  logic [WIDTH-1:0] terma,
  output logic             gnta,
  output logic             donea,
  input  logic             reqb,
  input  logic [WIDTH-1:0] startb,
  input  logic [WIDTH-1:0] termb,
  output logic             gntb,
  output logic             doneb,
  output logic             busy,
  output logic             enable,
  output logic             load,
  output logic [0:WIDTH-1] data,
  input  logic [0:WIDTH-1] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic             owner_b_reg;
  logic             last_a_reg;
  logic [0:WIDTH-1] term_reg;
  logic [0:WIDTH-1] data_reg;
  logic [1:0]       gnt_reg;
  logic [1:0]       done_reg;
  logic             load_reg;

  logic             grant_any;
  logic             grant_b;

  // Ties go to whoever was not served last; last_a_reg clears to 0 so A wins after reset.
  assign grant_any = reqa | reqb;
  assign grant_b   = reqb & (~reqa | last_a_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_b_reg <= 1'b0;
      last_a_reg  <= 1'b0;
      term_reg    <= '0;
      data_reg    <= '0;
      gnt_reg     <= 2'b00;
      done_reg    <= 2'b00;
      load_reg    <= 1'b0;
    end else begin
      gnt_reg  <= 2'b00;
      done_reg <= 2'b00;
      load_reg <= 1'b0;
      case (state_reg)
        // DONE arbitrates like IDLE so a pending request is taken on the edge leaving DONE.
        IDLE, DONE: begin
          if (grant_any) begin
            owner_b_reg <= grant_b;
            term_reg    <= grant_b ? termb : terma;
            data_reg    <= grant_b ? startb : starta;
            load_reg    <= 1'b1;
            gnt_reg     <= grant_b ? 2'b10 : 2'b01;
            state_reg   <= LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end
        LOAD: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (count == term_reg) begin
            done_reg   <= owner_b_reg ? 2'b10 : 2'b01;
            last_a_reg <= ~owner_b_reg;
            state_reg  <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Enable follows the live count so the increment stops exactly on the terminal value.
  assign enable = (state_reg == RUN) && (count != term_reg);
  assign busy   = (state_reg != IDLE);
  assign load   = load_reg;
  assign data   = data_reg;
  assign gnta   = gnt_reg[0];
  assign gntb   = gnt_reg[1];
  assign donea  = done_reg[0];
  assign doneb  = done_reg[1];

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus randomized jobs checked against
// a job-level model (winner choice, increment count k, grant-to-done latency k+2).
module tb_counter_sequencer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         reqa = 1'b0, reqb = 1'b0;
  logic [W-1:0] starta = '0, terma = '0, startb = '0, termb = '0;
  logic         gnta, donea, gntb, doneb, busy, enable, load;
  logic [0:W-1] data;
  logic [0:W-1] count = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit model_last_a = 1'b0;

  always #5 clock = ~clock;

  // Environment counter: load has priority over enable.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (load) count <= data;
    else if (enable) count <= count + 1'b1;
  end

  counter_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .reqa(reqa), .starta(starta), .terma(terma), .gnta(gnta), .donea(donea),
    .reqb(reqb), .startb(startb), .termb(termb), .gntb(gntb), .doneb(doneb),
    .busy(busy), .enable(enable), .load(load), .data(data), .count(count)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Serve one job for the given owner; b2b means the grant must follow the previous Done directly.
  task automatic serve(input bit own_b, input logic [7:0] st, input logic [7:0] tm, input bit b2b);
    logic [7:0] kk;
    int k, waited, gnt_cyc, n, en;
    bit got, done, bad;
    kk = tm - st;
    k = int'(kk);
    waited = 0; got = 0;
    while (!got && waited < 20) begin
      step();
      waited++;
      if (gnta || gntb) got = 1;
    end
    chk("gnt_seen", 32'(got), 1);
    if (!got) return;
    if (b2b) chk("gnt_after_done", cyc - last_done_cyc, 1);
    chk("gnta", 32'(gnta), 32'(!own_b));
    chk("gntb", 32'(gntb), 32'(own_b));
    chk("load", 32'(load), 1);
    chk("data", 32'(data), 32'(st));
    chk("enable_in_load", 32'(enable), 0);
    chk("busy_in_load", 32'(busy), 1);
    gnt_cyc = cyc;
    if (own_b) begin
      reqb = 1'b0; startb = 8'($urandom); termb = 8'($urandom);
    end else begin
      reqa = 1'b0; starta = 8'($urandom); terma = 8'($urandom);
    end
    n = 0; en = 0; done = 0; bad = 0;
    while (!done && n < k + 10) begin
      step();
      n++;
      if (gnta || gntb) bad = 1;
      if (enable) en++;
      if (donea || doneb) done = 1;
    end
    chk("done_seen", 32'(done), 1);
    if (!done) return;
    chk("gnt_during_job", 32'(bad), 0);
    chk("done_latency", cyc - gnt_cyc, k + 2);
    chk("enable_cycles", en, k);
    chk("enable_at_done", 32'(enable), 0);
    chk("count_at_done", 32'(count), 32'(tm));
    chk("donea", 32'(donea), 32'(!own_b));
    chk("doneb", 32'(doneb), 32'(own_b));
    chk("busy_at_done", 32'(busy), 1);
    model_last_a = !own_b;
    last_done_cyc = cyc;
    $display("job owner=%s start=%0d term=%0d k=%0d enables=%0d latency=%0d",
             own_b ? "B" : "A", st, tm, k, en, cyc - gnt_cyc);
  endtask

  // Present requests; when both ask, the one not served most recently goes first.
  task automatic job(input bit ra, input bit rb, input logic [7:0] sa, input logic [7:0] ta,
                     input logic [7:0] sb, input logic [7:0] tb2);
    bit first_b;
    starta = sa; terma = ta; startb = sb; termb = tb2;
    reqa = ra; reqb = rb;
    if (ra && rb) begin
      if (model_last_a) first_b = 1'b1;
      else first_b = 1'b0;
      if (first_b) begin
        serve(1'b1, sb, tb2, 1'b0);
        serve(1'b0, sa, ta, 1'b1);
      end else begin
        serve(1'b0, sa, ta, 1'b0);
        serve(1'b1, sb, tb2, 1'b1);
      end
    end else if (ra) begin
      serve(1'b0, sa, ta, 1'b0);
    end else begin
      serve(1'b1, sb, tb2, 1'b0);
    end
    step();
  endtask

  initial begin
    bit hit;
    int n;
    logic [7:0] sa, ta, sb, tb2;
    bit ra, rb;

    // Reset and idle behaviour
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_gnt", {30'd0, gnta, gntb}, 0);
    chk("rst_done", {30'd0, donea, doneb}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_quiet", {28'd0, gnta, gntb, busy, donea | doneb}, 0);
    end

    job(1'b1, 1'b0, 8'd10, 8'd15, 8'd0, 8'd0);
    job(1'b1, 1'b1, 8'd0, 8'd2, 8'd5, 8'd6);
    job(1'b1, 1'b1, 8'd0, 8'd2, 8'd5, 8'd6);
    job(1'b0, 1'b1, 8'd0, 8'd0, 8'd250, 8'd3);
    job(1'b1, 1'b0, 8'd42, 8'd42, 8'd0, 8'd0);

    // Abort a running job with reset
    starta = 8'd0; terma = 8'd200; reqa = 1'b1;
    hit = 0; n = 0;
    while (!hit && n < 20) begin step(); n++; if (gnta) hit = 1; end
    chk("abort_gnt", 32'(hit), 1);
    reqa = 1'b0;
    hit = 0; n = 0;
    while (!hit && n < 100) begin step(); n++; if (count == 8'd50) hit = 1; end
    chk("abort_reach_50", 32'(hit), 1);
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_enable", 32'(enable), 0);
    chk("abort_load", 32'(load), 0);
    chk("abort_data", 32'(data), 0);
    chk("abort_outs", {28'd0, gnta, gntb, donea, doneb}, 0);
    reset = 1'b0;
    model_last_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", {29'd0, donea, enable, busy}, 0);
    end
    $display("reset abort checked at count=50");
    job(1'b1, 1'b1, 8'd7, 8'd9, 8'd20, 8'd21);

    // Randomized jobs
    for (int it = 0; it < 20; it++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      sa = 8'($urandom); sb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ta = 8'($urandom);
      else ta = sa + 8'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) tb2 = 8'($urandom);
      else tb2 = sb + 8'($urandom_range(0, 20));
      job(ra, rb, sa, ta, sb, tb2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
